// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter
//   Shares the single-port data RAM between the CPU datapath and a debug/loader
//   requester. The CPU wins whenever it asks; the debug port is served in idle
//   CPU cycles. mem_* are muxed from the winner in the same cycle. Read data
//   from the RAM arrives one cycle later and is routed by a registered owner.
//
//   Build option: define ARB_STARVE_GUARD_EN to add a starvation counter that
//   forces one debug grant (stalling the CPU) after STARVE_MAX lost cycles.
//   Without it the CPU has strict priority and cpu_stall is tied low.
//
//   While reset is asserted every output is held at zero, including the
//   combinational ones that would otherwise follow the request inputs.

module data_mem_arbiter #(
  parameter int ADDR_W     = 11,
  parameter int DATA_W     = 16,
  parameter int STARVE_MAX = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_rd,
  input  logic              cpu_wr,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  input  logic              dbg_req,
  input  logic              dbg_wr,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              dbg_gnt,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              dbg_rvalid,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  // Who issued the read that the RAM answers in the following cycle.
  // Writes leave the owner at OWN_NONE since nothing comes back.
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_DBG  = 2'd2
  } owner_e;

  owner_e owner_d, owner_q;

  logic              cpu_req_s;
  logic              forced_s;
  logic              grant_cpu_s;
  logic              grant_dbg_s;
  logic              mem_rd_s;
  logic              mem_wr_s;
  logic [ADDR_W-1:0] mem_addr_d, mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_d, mem_wdata_q;
  logic [DATA_W-1:0] cpu_rdata_d, cpu_rdata_q;
  logic [DATA_W-1:0] dbg_rdata_d, dbg_rdata_q;

  assign cpu_req_s = cpu_rd | cpu_wr;

`ifdef ARB_STARVE_GUARD_EN
  localparam int CNT_W = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

  logic [CNT_W-1:0] starve_d, starve_q;

  // A saturated counter with a live request takes the RAM away from the CPU.
  assign forced_s = dbg_req & (starve_q == STARVE_LIM);

  // Count cycles the debug port waited in vain; any grant or a dropped request restarts it.
  always_comb begin
    starve_d = starve_q;
    if (!dbg_req || grant_dbg_s) begin
      starve_d = {CNT_W{1'b0}};
    end else if (starve_q != STARVE_LIM) begin
      starve_d = starve_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      starve_d = starve_q;
    end
  end

  // Starvation counter register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      starve_q <= {CNT_W{1'b0}};
    end else begin
      starve_q <= starve_d;
    end
  end

  assign cpu_stall = reset & cpu_req_s & forced_s;
`else
  // STARVE_MAX has no role when the guard is left out.
  logic unused_starve_s;
  assign unused_starve_s = (STARVE_MAX > 0);

  assign forced_s  = 1'b0;
  assign cpu_stall = 1'b0;
`endif

  // Priority: forced debug > CPU > debug > none.
  assign grant_dbg_s = forced_s | (dbg_req & ~cpu_req_s);
  assign grant_cpu_s = cpu_req_s & ~forced_s;

  // Steer the winner onto the RAM port and note who expects read data next cycle.
  always_comb begin
    mem_rd_s    = 1'b0;
    mem_wr_s    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    owner_d     = OWN_NONE;
    if (grant_dbg_s) begin
      mem_wr_s    = dbg_wr;
      mem_rd_s    = ~dbg_wr;
      mem_addr_d  = dbg_addr;
      mem_wdata_d = dbg_wdata;
      owner_d     = dbg_wr ? OWN_NONE : OWN_DBG;
    end else if (grant_cpu_s) begin
      // A simultaneous read and write strobe is treated as a write.
      mem_wr_s    = cpu_wr;
      mem_rd_s    = ~cpu_wr;
      mem_addr_d  = cpu_addr;
      mem_wdata_d = cpu_wdata;
      owner_d     = cpu_wr ? OWN_NONE : OWN_CPU;
    end else begin
      // Idle: strobes low, address and data keep their last values.
      mem_rd_s    = 1'b0;
      mem_wr_s    = 1'b0;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      owner_d     = OWN_NONE;
    end
  end

  // Route returning RAM data to its requester; the other side keeps its last word.
  always_comb begin
    cpu_rdata_d = cpu_rdata_q;
    dbg_rdata_d = dbg_rdata_q;
    case (owner_q)
      OWN_CPU: cpu_rdata_d = mem_rdata;
      OWN_DBG: dbg_rdata_d = mem_rdata;
      OWN_NONE: begin
        cpu_rdata_d = cpu_rdata_q;
        dbg_rdata_d = dbg_rdata_q;
      end
      default: begin
        cpu_rdata_d = cpu_rdata_q;
        dbg_rdata_d = dbg_rdata_q;
      end
    endcase
  end

  // Owner, held RAM address/data and captured read words.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      owner_q     <= OWN_NONE;
      mem_addr_q  <= {ADDR_W{1'b0}};
      mem_wdata_q <= {DATA_W{1'b0}};
      cpu_rdata_q <= {DATA_W{1'b0}};
      dbg_rdata_q <= {DATA_W{1'b0}};
    end else begin
      owner_q     <= owner_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      cpu_rdata_q <= cpu_rdata_d;
      dbg_rdata_q <= dbg_rdata_d;
    end
  end

  assign dbg_gnt    = reset & grant_dbg_s;
  assign dbg_rvalid = reset & (owner_q == OWN_DBG);
  assign mem_rd     = reset & mem_rd_s;
  assign mem_wr     = reset & mem_wr_s;
  assign mem_addr   = reset ? mem_addr_d  : {ADDR_W{1'b0}};
  assign mem_wdata  = reset ? mem_wdata_d : {DATA_W{1'b0}};
  assign cpu_rdata  = reset ? cpu_rdata_d : {DATA_W{1'b0}};
  assign dbg_rdata  = reset ? dbg_rdata_d : {DATA_W{1'b0}};

endmodule
